// File: rtl/gpu_cmd_sender.sv
// Host-side serialiser for the GPU command port: turns one draw request into a
// header word plus back-to-back payload words on dv/din, gated by the GPU's ready.
module gpu_cmd_sender #(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned WIDTH    = 640,
   parameter int unsigned HEIGHT   = 480,
   parameter logic [15:0] GPU_SWAP  = 16'h0001,
   parameter logic [15:0] GPU_CMAP  = 16'h0002,
   parameter logic [15:0] GPU_PIXEL = 16'h0003,
   parameter logic [15:0] GPU_RECT  = 16'h0004
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [DEPTH-1:0] req_color,
   input  logic [9:0]       req_x,
   input  logic [9:0]       req_y,
   input  logic [9:0]       req_w,
   input  logic [9:0]       req_h,
   input  logic [95:0]      req_cmap,
   output logic             dv,
   output logic [31:0]      din,
   input  logic             ready,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HDR, S_PAY, S_GAP} state_t;

   localparam logic [1:0]  OP_SWAP  = 2'd0;
   localparam logic [1:0]  OP_CMAP  = 2'd1;
   localparam logic [1:0]  OP_PIXEL = 2'd2;
   localparam logic [1:0]  OP_RECT  = 2'd3;
   localparam logic [10:0] W_LIM    = 11'(WIDTH);
   localparam logic [10:0] H_LIM    = 11'(HEIGHT);

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [DEPTH-1:0]   color_q, color_d;
   logic [9:0]         x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
   logic [95:0]        cmap_q, cmap_d;
   logic [1:0]         k_q, k_d;
   logic               dv_q, dv_d, done_q, done_d, err_q, err_d;
   logic [31:0]        din_q, din_d;

   // Request validation and clipping, evaluated on the live request fields.
   logic [10:0] x_ext, y_ext, x_end, y_end;
   logic [9:0]  w_clip, h_clip;
   logic        req_bad;

   assign x_ext   = {1'b0, req_x};
   assign y_ext   = {1'b0, req_y};
   assign x_end   = x_ext + {1'b0, req_w};
   assign y_end   = y_ext + {1'b0, req_h};
   assign w_clip  = (x_end > W_LIM) ? 10'(W_LIM - x_ext) : req_w;
   assign h_clip  = (y_end > H_LIM) ? 10'(H_LIM - y_ext) : req_h;
   assign req_bad = (req_op[1] && ((x_ext >= W_LIM) || (y_ext >= H_LIM))) ||
                    ((req_op == OP_RECT) && ((req_w == '0) || (req_h == '0)));

   logic [2:0]  pay_cnt;
   logic        pay_last;
   logic [1:0]  pay_idx;
   logic [31:0] hdr_word, pay_word;
   logic [23:0] cmap_ent;

   always_comb begin
      hdr_word = '0;
      pay_cnt  = 3'd2;
      case (op_q)
         OP_SWAP:  begin hdr_word[15:0] = GPU_SWAP;  pay_cnt = 3'd0; end
         OP_CMAP:  begin hdr_word[15:0] = GPU_CMAP;  pay_cnt = 3'd4; end
         OP_PIXEL: begin hdr_word[15:0] = GPU_PIXEL; pay_cnt = 3'd1; end
         default:  begin hdr_word[15:0] = GPU_RECT;  pay_cnt = 3'd2; end
      endcase
      if (op_q[1])
         hdr_word[16 +: DEPTH] = color_q;
   end

   assign pay_last = ({1'b0, k_q} == (pay_cnt - 3'd1));
   // Index of the word to load next: word 0 from HDR, otherwise the one after k.
   assign pay_idx  = (state_q == S_HDR) ? 2'd0 : (k_q + 2'd1);

   always_comb begin
      case (pay_idx)
         2'd0:    cmap_ent = cmap_q[23:0];
         2'd1:    cmap_ent = cmap_q[47:24];
         2'd2:    cmap_ent = cmap_q[71:48];
         default: cmap_ent = cmap_q[95:72];
      endcase
      case (op_q)
         OP_CMAP:  pay_word = {8'b0, cmap_ent};
         OP_PIXEL: pay_word = {6'b0, y_q, 6'b0, x_q};
         OP_RECT:  pay_word = (pay_idx == 2'd0) ? {6'b0, y_q, 6'b0, x_q}
                                                : {6'b0, h_q, 6'b0, w_q};
         default:  pay_word = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      color_d = color_q;
      x_d     = x_q;
      y_d     = y_q;
      w_d     = w_q;
      h_d     = h_q;
      cmap_d  = cmap_q;
      k_d     = k_q;
      dv_d    = dv_q;
      din_d   = din_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            dv_d  = 1'b0;
            din_d = '0;
            if (req_valid) begin
               op_d    = req_op;
               color_d = req_color;
               x_d     = req_x;
               y_d     = req_y;
               w_d     = w_clip;
               h_d     = h_clip;
               cmap_d  = req_cmap;
               if (req_bad) err_d   = 1'b1;
               else         state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ready) begin
               dv_d    = 1'b1;
               din_d   = hdr_word;
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            if (pay_cnt == 3'd0) begin
               dv_d    = 1'b0;
               din_d   = '0;
               done_d  = 1'b1;
               state_d = S_GAP;
            end else begin
               din_d   = pay_word;
               k_d     = 2'd0;
               state_d = S_PAY;
            end
         end
         S_PAY: begin
            if (pay_last) begin
               dv_d    = 1'b0;
               din_d   = '0;
               done_d  = 1'b1;
               state_d = S_GAP;
            end else begin
               din_d   = pay_word;
               k_d     = k_q + 2'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         color_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
         cmap_q  <= '0;
         k_q     <= '0;
         dv_q    <= 1'b0;
         din_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         color_q <= color_d;
         x_q     <= x_d;
         y_q     <= y_d;
         w_q     <= w_d;
         h_q     <= h_d;
         cmap_q  <= cmap_d;
         k_q     <= k_d;
         dv_q    <= dv_d;
         din_q   <= din_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign dv        = dv_q;
   assign din       = din_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: doc/gpu_cmd_sender.md
Name: gpu_cmd_sender

Overview:
- Host-side transmitter for the GPU command port (dv/din/ready). It accepts one high-level draw request at a time: Swap, ChangeColorMap, Pixel or Rect.
- It serialises each request into the exact word sequence the GPU consumes: one header word, then payload words on back-to-back cycles with no stalls.
- Sits between the CPU/MMIO command path and the GPU. The GPU shares clk and rst with it.

Parameters:
- DEPTH, 2, bits per pixel colour index; must match Display.vh.
- WIDTH, 640, screen width in pixels; used for validation and clipping.
- HEIGHT, 480, screen height in pixels; used for validation and clipping.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted on this edge when req_valid is also high
- req_op  in  2  0=Swap, 1=ChangeColorMap, 2=Pixel, 3=Rect
- req_color  in  DEPTH  draw colour index (Pixel/Rect)
- req_x, req_y  in  10 each  origin
- req_w, req_h  in  10 each  Rect size
- req_cmap  in  96  four 24-bit colours; entry i is bits [24i+23:24i]
- dv  out  1  GPU data valid (registered)
- din  out  32  GPU data word (registered)
- ready  in  1  GPU idle / can take a header
- busy  out  1  high whenever not in IDLE
- done  out  1  one-cycle pulse when a sequence completes
- err  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset values: dv=0, din=0, done=0, err=0, busy=0, req_ready=1; state IDLE.
- Reset mid-sequence: dv drops on the next edge and any partial sequence is abandoned. The GPU shares rst, so no recovery is needed.
- Word formats:
  - Header: din[15:0] = `GPU_* code from GPUcommands.vh; din[16+DEPTH-1:16] = colour; all other bits 0.
  - Point word: {6'b0, y[9:0], 6'b0, x[9:0]}.
  - Colour-map word i: {8'b0, entry i}.
- Payload per op:
  - Swap: none.
  - ChangeColorMap: 4 words, entries 0..3 in order.
  - Pixel: 1 word, (x,y).
  - Rect: 2 words, (x,y) then (w,h).
- States: IDLE, WAIT, HDR, PAY, GAP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all request fields and validate (rules below).
  - Invalid request: err pulses the next cycle; stay in IDLE.
  - Valid request: go to WAIT.
- Validation and clipping:
  - Pixel/Rect with x>=WIDTH or y>=HEIGHT: reject.
  - Rect with w==0 or h==0: reject.
  - Rect with x+w>WIDTH: clip w to WIDTH-x.
  - Rect with y+h>HEIGHT: clip h to HEIGHT-y.
  - Clipping sums use 11-bit arithmetic; no wrap.
- WAIT: when ready is sampled high, register dv=1 and din=header, then go to HDR. Latency from ready high to header on the port is exactly 1 cycle.
- HDR (header on the port):
  - If the payload count is 0: next dv=0, go to GAP.
  - Otherwise: next din = payload word 0, dv stays 1, payload index k=0, go to PAY.
- PAY:
  - Payload words go out on consecutive cycles with dv=1 throughout.
  - ready is ignored here: the GPU samples payload without checking dv or ready.
  - After the last word: dv=0, din=0, go to GAP.
- GAP:
  - Exactly one cycle with dv=0; done pulses in this cycle; then go to IDLE.
  - Purpose: a stale ready=1 can never launch a header in the same cycle the previous payload ended.
  - A new header is sent only after WAIT samples ready=1 while dv=0.
- Invariants:
  - dv is never high in IDLE or WAIT.
  - dv is high for exactly 1+payload_count consecutive cycles per sequence.
- Simultaneous events:
  - A new req_valid during busy is not accepted (req_ready=0).
  - A request presented in the same cycle as the done pulse is accepted on the following cycle, in IDLE.
- Total cycles from acceptance to done (GPU ready already high): 3 + payload_count.

Test Plan:
- Reset, then Pixel x=5 y=7 colour=2 with ready=1 -> dv high 2 cycles; din = 0x0002_0000|`GPU_Pixel, then 0x0007_0005; done 1 cycle after dv falls.
- ChangeColorMap, req_cmap = 96'hffffff_00ffff_ff0000_ffbbbb -> header, then 0x00ffbbbb, 0x00ff0000, 0x0000ffff, 0x00ffffff on consecutive cycles; dv high exactly 5 cycles.
- Rect x=630 y=470 w=20 h=20 (640x480) -> payload words 0x01d6_0276 and 0x000a_000a (clipped to w=10, h=10).
- Rect w=0, and Pixel x=640 -> err pulse each, dv stays 0, busy never high.
- Swap issued with ready held 0 for 10 cycles then raised -> header appears exactly 1 cycle after ready rises; dv high 1 cycle only; done follows.
- Two back-to-back Pixel requests with ready stuck at 1 -> at least 1 dv=0 cycle between sequences; assert rst during the second payload -> dv=0 next cycle, no done pulse.
